// File: rtl/rv32i_types.sv
// Shared types for the rv32i core's pipeline control: hazard FSM states and
// stage-register indices used by the load/flush vectors.
package rv32i_types;

    typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} hazard_state_t;

    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    typedef logic [3:0] stage_vec_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: resets to zero, counts each cycle inc is high and
// sticks at all-ones once reached.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (inc && value != '1)
            value <= value + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load/flush control for the 5-stage pipeline: memory-wait freeze, load-use
// bubble, redirect squash. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read_i,
    input  logic             imem_resp_i,
    input  logic             dmem_access_i,
    input  logic             dmem_resp_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    output logic             pc_load_o,
    output stage_vec_t       stage_load_o,
    output stage_vec_t       stage_flush_o,
    output logic             imem_hold_o,
    output logic             dmem_hold_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_mem_stall_o,
    output logic [CNT_W-1:0] perf_lu_stall_o,
    output logic [CNT_W-1:0] perf_flush_o
`endif
);

    localparam stage_vec_t FLUSH_MASK = stage_vec_t'((5'd1 << FLUSH_DEPTH) - 5'd1);

    hazard_state_t state;
    logic          imem_done, dmem_done;
    logic          ok_i, ok_d, advance, load_use;

    assign ok_i    = !imem_read_i   || imem_resp_i || imem_done;
    assign ok_d    = !dmem_access_i || dmem_resp_i || dmem_done;
    assign advance = ok_i && ok_d;

    assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && id_rs1_i == ex_rd_i) ||
                       (id_use_rs2_i && id_rs2_i == ex_rd_i));

    // Done flags remember a response that arrived while the other side was still busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!advance) begin
                        state     <= MEM_WAIT;
                        imem_done <= imem_resp_i;
                        dmem_done <= dmem_resp_i;
                    end
                end
                MEM_WAIT: begin
                    if (advance) begin
                        state     <= RUN;
                        imem_done <= 1'b0;
                        dmem_done <= 1'b0;
                    end else begin
                        imem_done <= imem_done || imem_resp_i;
                        dmem_done <= dmem_done || dmem_resp_i;
                    end
                end
                default: begin
                    state     <= RUN;
                    imem_done <= 1'b0;
                    dmem_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_load_o     = 1'b0;
        stage_load_o  = '0;
        stage_flush_o = '0;
        if (!rst && advance) begin
            if (ex_redirect_i) begin
                pc_load_o     = 1'b1;
                stage_load_o  = 4'hF;
                stage_flush_o = FLUSH_MASK;
            end else if (load_use) begin
                // Younger instructions hold; a bubble is clocked into ID/EX.
                stage_load_o[STG_EX_MEM] = 1'b1;
                stage_load_o[STG_MEM_WB] = 1'b1;
                stage_flush_o[STG_ID_EX] = 1'b1;
            end else begin
                pc_load_o    = 1'b1;
                stage_load_o = 4'hF;
            end
        end
    end

    assign imem_hold_o = !rst && imem_done;
    assign dmem_hold_o = !rst && dmem_done;

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_cnt_mem (
        .clk(clk), .rst(rst), .inc(!advance), .value(perf_mem_stall_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
        .clk(clk), .rst(rst), .inc(advance && load_use && !ex_redirect_i), .value(perf_lu_stall_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk(clk), .rst(rst), .inc(advance && ex_redirect_i), .value(perf_flush_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (FLUSH_DEPTH=2, CNT_W=4).
module tb_pipeline_hazard_ctrl;
    import rv32i_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_read, imem_resp, dmem_access, dmem_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
    logic       pc_load, imem_hold, dmem_hold;
    stage_vec_t stage_load, stage_flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] perf_mem_stall, perf_lu_stall, perf_flush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(.FLUSH_DEPTH(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .imem_read_i(imem_read), .imem_resp_i(imem_resp),
        .dmem_access_i(dmem_access), .dmem_resp_i(dmem_resp),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_redirect_i(ex_redirect),
        .pc_load_o(pc_load), .stage_load_o(stage_load), .stage_flush_o(stage_flush),
        .imem_hold_o(imem_hold), .dmem_hold_o(dmem_hold)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_mem_stall_o(perf_mem_stall), .perf_lu_stall_o(perf_lu_stall),
        .perf_flush_o(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packs {pc_load, stage_load, stage_flush, imem_hold, dmem_hold}.
    task automatic chk_out(input string tag, input logic pc, input logic [3:0] ld,
                           input logic [3:0] fl, input logic ih, input logic dh);
        chk(tag, {21'd0, pc_load, stage_load, stage_flush, imem_hold, dmem_hold},
                 {21'd0, pc, ld, fl, ih, dh});
    endtask

    // Sample mid-low-phase, then move to the next negedge (one rising edge in between).
    task automatic settle_and_next(input string tag, input logic pc, input logic [3:0] ld,
                                   input logic [3:0] fl, input logic ih, input logic dh);
        #1;
        chk_out(tag, pc, ld, fl, ih, dh);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_read = 1'b1; imem_resp = 1'b1; dmem_access = 1'b0; dmem_resp = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        settle_and_next("reset_forced_zero", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            settle_and_next($sformatf("normal_%0d", i), 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);

        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        settle_and_next("load_use_rs2", 1'b0, 4'hC, 4'h2, 1'b0, 1'b0);
        ex_rd = 5'd0; id_rs2 = 5'd0;
        settle_and_next("load_use_x0", 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs2 = 1'b0; id_use_rs1 = 1'b0;
        settle_and_next("rs1_match_unused", 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
        id_use_rs1 = 1'b1;
        settle_and_next("load_use_rs1", 1'b0, 4'hC, 4'h2, 1'b0, 1'b0);
        ex_redirect = 1'b1;
        settle_and_next("redirect_over_lu", 1'b1, 4'hF, 4'h3, 1'b0, 1'b0);
        idle_inputs();

        // imem responds at cycle 0, dmem at cycle 4.
        dmem_access = 1'b1;
        settle_and_next("memwait_c0", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        imem_resp = 1'b0;
        for (int c = 1; c <= 3; c++)
            settle_and_next($sformatf("memwait_c%0d", c), 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        dmem_resp = 1'b1;
        settle_and_next("memwait_c4_adv", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
        idle_inputs();
        settle_and_next("memwait_c5_run", 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);

        // dmem responds first; imem completes the advance a cycle later.
        imem_resp = 1'b0; dmem_access = 1'b1; dmem_resp = 1'b1;
        settle_and_next("dfirst_c0", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        imem_resp = 1'b1; dmem_resp = 1'b0;
        settle_and_next("dfirst_c1_adv", 1'b1, 4'hF, 4'h0, 1'b0, 1'b1);
        idle_inputs();

        // Redirect waits out a stall, then squashes on the advancing cycle.
        imem_read = 1'b0; imem_resp = 1'b0; dmem_access = 1'b1; ex_redirect = 1'b1;
        settle_and_next("redir_stall", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        dmem_resp = 1'b1;
        settle_and_next("redir_after_stall", 1'b1, 4'hF, 4'h3, 1'b0, 1'b0);
        idle_inputs();

        // Reset in MEM_WAIT with imem_done set must drop the captured response.
        dmem_access = 1'b1;
        settle_and_next("rstmid_enter", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        imem_resp = 1'b0;
        settle_and_next("rstmid_hold", 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        rst = 1'b1;
        settle_and_next("rstmid_in_rst", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0; dmem_access = 1'b0;
        settle_and_next("rstmid_needs_resp", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        imem_resp = 1'b1;
        settle_and_next("rstmid_fresh_resp", 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        imem_resp = 1'b0;
        for (int c = 0; c < 20; c++) @(negedge clk);
        #1;
        chk("perf_mem_sat", {28'd0, perf_mem_stall}, 32'd15);
        idle_inputs();
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
